// File: rtl/intersection_ctrl_n.sv
// rtl/intersection_ctrl_n.sv - multi-intersection traffic light controller with VIP preemption
module intersection_ctrl_n #(
    parameter int NUM_X     = 2,
    parameter int TW        = 16,
    parameter int GREEN_T   = 40,
    parameter int YELLOW_T  = 5,
    parameter int LEFT_T    = 10,
    parameter int WALK_T    = 30,
    parameter int BLINK_T   = 10,
    parameter int BLINK_DIV = 2,
    parameter int ALL_RED_T = 3,
    parameter int OFFSET_T  = 8,
    parameter int VIP_EXCL  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_X-1:0]     vip_req,
    output logic [4*NUM_X-1:0]   car_traffic,
    output logic [2*NUM_X-1:0]   walk_traffic,
    output logic [NUM_X-1:0]     vip_grant
);

    typedef enum logic [2:0] {
        S_IDLE, S_ALL_RED, S_GREEN, S_YELLOW, S_LEFT, S_WALK, S_BLINK, S_VIP_G
    } state_t;

    // Counter reload values: a state lasting T cycles loads T-1 and exits at 0
    localparam logic [TW-1:0] ALL_RED_L = TW'(ALL_RED_T - 1);
    localparam logic [TW-1:0] GREEN_L   = TW'(GREEN_T - 1);
    localparam logic [TW-1:0] YELLOW_L  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] LEFT_L    = (LEFT_T > 0) ? TW'(LEFT_T - 1) : '0;
    localparam logic [TW-1:0] WALK_L    = TW'(WALK_T - 1);
    localparam logic [TW-1:0] BLINK_L   = TW'(BLINK_T - 1);
    localparam logic [TW-1:0] BDIV_L    = TW'(BLINK_DIV - 1);

    state_t          state     [NUM_X];
    state_t          state_nxt [NUM_X];
    logic [TW-1:0]   cnt       [NUM_X];
    logic [TW-1:0]   cnt_nxt   [NUM_X];
    logic [TW-1:0]   bdiv      [NUM_X];
    logic [TW-1:0]   bdiv_nxt  [NUM_X];
    logic            blink     [NUM_X];
    logic            blink_nxt [NUM_X];
    logic [NUM_X-1:0] grant_nxt;

    function automatic logic [3:0] car_lamp(input state_t s);
        case (s)
            S_GREEN, S_VIP_G: car_lamp = 4'b0001;
            S_YELLOW:         car_lamp = 4'b0100;
            S_LEFT:           car_lamp = 4'b1010;
            default:          car_lamp = 4'b1000;
        endcase
    endfunction

    function automatic logic [1:0] walk_lamp(input state_t s, input logic b);
        case (s)
            S_WALK:  walk_lamp = 2'b01;
            S_BLINK: walk_lamp = {1'b0, b};
            default: walk_lamp = 2'b10;
        endcase
    endfunction

    // Grant arbitration: pass-through, or sticky holder with lowest-index pick when free
    always_comb begin
        grant_nxt = '0;
        if (start) begin
            if (VIP_EXCL == 0)
                grant_nxt = vip_req;
            else if ((vip_grant & vip_req) != '0)
                grant_nxt = vip_grant;
            else
                grant_nxt = vip_req & (~vip_req + NUM_X'(1));
        end
    end

    // Per-intersection next-state, counter and blink logic
    always_comb begin
        for (int i = 0; i < NUM_X; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            bdiv_nxt[i]  = bdiv[i];
            blink_nxt[i] = blink[i];
            if (!start) begin
                state_nxt[i] = S_IDLE;
                cnt_nxt[i]   = '0;
                bdiv_nxt[i]  = '0;
                blink_nxt[i] = 1'b0;
            end else begin
                case (state[i])
                    S_IDLE: begin
                        state_nxt[i] = S_ALL_RED;
                        cnt_nxt[i]   = ALL_RED_L + TW'(i * OFFSET_T);
                    end
                    S_ALL_RED: begin
                        if (cnt[i] == '0) begin
                            if (vip_grant[i]) begin
                                state_nxt[i] = S_VIP_G;
                            end else begin
                                state_nxt[i] = S_GREEN;
                                cnt_nxt[i]   = GREEN_L;
                            end
                        end else begin
                            cnt_nxt[i] = cnt[i] - TW'(1);
                        end
                    end
                    S_GREEN: begin
                        if (vip_grant[i]) begin
                            state_nxt[i] = S_VIP_G;
                        end else if (cnt[i] == '0) begin
                            state_nxt[i] = S_YELLOW;
                            cnt_nxt[i]   = YELLOW_L;
                        end else begin
                            cnt_nxt[i] = cnt[i] - TW'(1);
                        end
                    end
                    S_VIP_G: begin
                        if (!vip_grant[i]) begin
                            state_nxt[i] = S_YELLOW;
                            cnt_nxt[i]   = YELLOW_L;
                        end
                    end
                    S_YELLOW: begin
                        if (cnt[i] == '0) begin
                            if (vip_grant[i]) begin
                                state_nxt[i] = S_ALL_RED;
                                cnt_nxt[i]   = ALL_RED_L;
                            end else if (LEFT_T > 0) begin
                                state_nxt[i] = S_LEFT;
                                cnt_nxt[i]   = LEFT_L;
                            end else begin
                                state_nxt[i] = S_WALK;
                                cnt_nxt[i]   = WALK_L;
                            end
                        end else begin
                            cnt_nxt[i] = cnt[i] - TW'(1);
                        end
                    end
                    S_LEFT: begin
                        if (vip_grant[i]) begin
                            state_nxt[i] = S_ALL_RED;
                            cnt_nxt[i]   = ALL_RED_L;
                        end else if (cnt[i] == '0) begin
                            state_nxt[i] = S_WALK;
                            cnt_nxt[i]   = WALK_L;
                        end else begin
                            cnt_nxt[i] = cnt[i] - TW'(1);
                        end
                    end
                    S_WALK: begin
                        if (vip_grant[i] || cnt[i] == '0) begin
                            state_nxt[i] = S_BLINK;
                            cnt_nxt[i]   = BLINK_L;
                            bdiv_nxt[i]  = BDIV_L;
                            blink_nxt[i] = 1'b1;
                        end else begin
                            cnt_nxt[i] = cnt[i] - TW'(1);
                        end
                    end
                    S_BLINK: begin
                        if (cnt[i] == '0) begin
                            state_nxt[i] = S_ALL_RED;
                            cnt_nxt[i]   = ALL_RED_L;
                            blink_nxt[i] = 1'b0;
                        end else begin
                            cnt_nxt[i] = cnt[i] - TW'(1);
                            if (bdiv[i] == '0) begin
                                blink_nxt[i] = ~blink[i];
                                bdiv_nxt[i]  = BDIV_L;
                            end else begin
                                bdiv_nxt[i] = bdiv[i] - TW'(1);
                            end
                        end
                    end
                    default: begin
                        state_nxt[i] = S_IDLE;
                        cnt_nxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    // State, counters, grant and lamps registered together; lamps decode the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vip_grant <= '0;
            for (int i = 0; i < NUM_X; i++) begin
                state[i]                <= S_IDLE;
                cnt[i]                  <= '0;
                bdiv[i]                 <= '0;
                blink[i]                <= 1'b0;
                car_traffic[4*i +: 4]   <= 4'b1000;
                walk_traffic[2*i +: 2]  <= 2'b10;
            end
        end else begin
            vip_grant <= grant_nxt;
            for (int i = 0; i < NUM_X; i++) begin
                state[i]                <= state_nxt[i];
                cnt[i]                  <= cnt_nxt[i];
                bdiv[i]                 <= bdiv_nxt[i];
                blink[i]                <= blink_nxt[i];
                car_traffic[4*i +: 4]   <= car_lamp(state_nxt[i]);
                walk_traffic[2*i +: 2]  <= walk_lamp(state_nxt[i], blink_nxt[i]);
            end
        end
    end

endmodule

// File: tb/tb_intersection_ctrl_n.sv
// tb/tb_intersection_ctrl_n.sv - directed scoreboard bench for intersection_ctrl_n
module tb_intersection_ctrl_n;
    localparam int NX = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [NX-1:0]   vip_req = '0;
    logic [4*NX-1:0] car_traffic;
    logic [2*NX-1:0] walk_traffic;
    logic [NX-1:0]   vip_grant;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;
    exp_t sb[$];

    intersection_ctrl_n #(.NUM_X(NX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .vip_req      (vip_req),
        .car_traffic  (car_traffic),
        .walk_traffic (walk_traffic),
        .vip_grant    (vip_grant)
    );

    always #5 clk = ~clk;

    function automatic int lamp0();
        return int'({car_traffic[3:0], walk_traffic[1:0]});
    endfunction

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input int obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < NX; i++)
                if ((car_traffic[4*i] || car_traffic[4*i+1]) && walk_traffic[2*i]) viol++;
        end
    endtask

    task automatic wait_lamp0(input int v, input string tag);
        int n;
        n = 0;
        while (lamp0() !== v && n < 300) begin
            step(1);
            n++;
        end
        sb_push(tag, v);
        sb_check(lamp0());
    endtask

    task automatic push_run(input string tag, input int v, input int len);
        sb_push({tag, "_val"}, v);
        sb_push({tag, "_len"}, len);
    endtask

    task automatic run_len(output int n);
        int v;
        v = lamp0();
        n = 0;
        while (lamp0() === v && n < 300) begin
            step(1);
            n++;
        end
        sb_check(v);
        sb_check(n);
    endtask

    initial begin
        int n;
        int sum;
        int hold_bad;
        int guard;

        // Reset state
        sb_push("rst_car", 'h88);
        sb_push("rst_walk", 'hA);
        sb_push("rst_grant", 0);
        step(3);
        sb_check(int'(car_traffic));
        sb_check(int'(walk_traffic));
        sb_check(int'(vip_grant));

        rst_n = 1'b1;
        step(2);

        // Start latency and green-wave stagger
        start = 1'b1;
        sb_push("pre_green0", 'h88);
        step(3);
        sb_check(int'(car_traffic));
        sb_push("green0", 'h81);
        step(1);
        sb_check(int'(car_traffic));
        sb_push("pre_green1", 'h81);
        step(7);
        sb_check(int'(car_traffic));
        sb_push("green1", 'h11);
        step(1);
        sb_check(int'(car_traffic));

        // Full normal cycle on intersection 0, measured as lamp run lengths
        wait_lamp0(6'b0100_10, "reach_yellow");
        push_run("yellow", 6'b0100_10, 5);
        push_run("left",   6'b1010_10, 10);
        push_run("walk",   6'b1000_01, 32);
        push_run("blink0", 6'b1000_00, 2);
        push_run("blink1", 6'b1000_01, 2);
        push_run("blink2", 6'b1000_00, 2);
        push_run("blink3", 6'b1000_01, 2);
        push_run("allred", 6'b1000_10, 3);
        push_run("green",  6'b0001_10, 40);
        sum = 0;
        for (int r = 0; r < 9; r++) begin
            run_len(n);
            sum += n;
        end
        sb_push("period", 98);
        sb_check(sum);

        // VIP during GREEN
        wait_lamp0(6'b0001_10, "reach_green");
        step(10);
        vip_req = 2'b01;
        sb_push("vip_grant_rise", 1);
        step(1);
        sb_check(int'(vip_grant));
        hold_bad = 0;
        for (int c = 0; c < 50; c++) begin
            step(1);
            if (car_traffic[3:0] !== 4'b0001) hold_bad++;
        end
        sb_push("vipg_hold", 0);
        sb_check(hold_bad);
        vip_req = 2'b00;
        sb_push("rel_grant", 0);
        sb_push("rel_car", 6'b0001_10);
        step(1);
        sb_check(int'(vip_grant));
        sb_check(lamp0());
        step(1);
        push_run("vip_yellow", 6'b0100_10, 5);
        push_run("vip_left",   6'b1010_10, 10);
        run_len(n);
        run_len(n);

        // VIP during WALK (now at first WALK cycle)
        vip_req = 2'b01;
        sb_push("walk_grant", 1);
        step(1);
        sb_check(int'(vip_grant));
        push_run("w_walk",   6'b1000_01, 3);
        push_run("w_blink0", 6'b1000_00, 2);
        push_run("w_blink1", 6'b1000_01, 2);
        push_run("w_blink2", 6'b1000_00, 2);
        push_run("w_blink3", 6'b1000_01, 2);
        push_run("w_allred", 6'b1000_10, 3);
        for (int r = 0; r < 6; r++) run_len(n);
        hold_bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (lamp0() !== 6'b0001_10) hold_bad++;
            step(1);
        end
        sb_push("w_vipg_hold", 0);
        sb_check(hold_bad);
        vip_req = 2'b00;
        sb_push("w_rel_car", 6'b0001_10);
        step(1);
        sb_check(lamp0());
        sb_push("w_rel_yellow", 6'b0100_10);
        step(1);
        sb_check(lamp0());

        // Exclusive arbitration
        vip_req = 2'b11;
        sb_push("arb_both", 1);
        step(1);
        sb_check(int'(vip_grant));
        vip_req = 2'b10;
        sb_push("arb_handover", 2);
        step(1);
        sb_check(int'(vip_grant));
        vip_req = 2'b11;
        sb_push("arb_holder_keeps", 2);
        step(1);
        sb_check(int'(vip_grant));
        vip_req = 2'b10;

        // Intersection 1 reaches VIP_G, then start drops
        guard = 0;
        while (car_traffic[7:4] !== 4'b0001 && guard < 300) begin
            step(1);
            guard++;
        end
        step(3);
        sb_push("i1_vipg", 1);
        sb_push("i1_grant", 2);
        sb_check(int'(car_traffic[7:4]));
        sb_check(int'(vip_grant));
        start = 1'b0;
        sb_push("stop_car", 'h88);
        sb_push("stop_walk", 'hA);
        sb_push("stop_grant", 0);
        step(1);
        sb_check(int'(car_traffic));
        sb_check(int'(walk_traffic));
        sb_check(int'(vip_grant));

        // Restart
        vip_req = 2'b00;
        start = 1'b1;
        sb_push("restart_green0", 'h81);
        step(4);
        sb_check(int'(car_traffic));

        // Asynchronous reset mid-phase
        step(20);
        #2;
        rst_n = 1'b0;
        #1;
        sb_push("async_rst_car", 'h88);
        sb_push("async_rst_walk", 'hA);
        sb_push("async_rst_grant", 0);
        sb_check(int'(car_traffic));
        sb_check(int'(walk_traffic));
        sb_check(int'(vip_grant));

        sb_push("lamp_conflicts", 0);
        sb_check(viol);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/intersection_ctrl_n.md
# intersection_ctrl_n

Parametrised multi-intersection traffic-light controller with emergency-vehicle (VIP) preemption. It drives NUM_X intersections from one clock. Each intersection runs an independent car/left-turn/pedestrian phase cycle, and intersection starts are staggered by a fixed offset to form a green wave. It sits directly below the board top-level: start/VIP slide switches in, lamp vectors out.

## Interface
- NUM_X, 2: number of intersections (1..8)
- TW, 16: phase timer width in bits
- GREEN_T, 40: car-green duration (cycles)
- YELLOW_T, 5: car-yellow duration
- LEFT_T, 10: left-arrow duration; 0 skips the LEFT state
- WALK_T, 30: pedestrian-green duration
- BLINK_T, 10: pedestrian-blink duration
- BLINK_DIV, 2: blink half-period (cycles)
- ALL_RED_T, 3: all-red clearance duration
- OFFSET_T, 8: per-index start stagger
- VIP_EXCL, 1: 1 = one VIP grant at a time; 0 = independent grants
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; 1 = run, 0 = hold all intersections in IDLE
- vip_req  in  NUM_X  per-intersection VIP request, level
- car_traffic  out  4*NUM_X  lamps {R,Y,L,G}, intersection i at [4i+3:4i]
- walk_traffic  out  2*NUM_X  lamps {R,G}, intersection i at [2i+1:2i]
- vip_grant  out  NUM_X  current VIP grant vector

## Operation
- One clock; reset is asynchronous and active-low.
- Per-intersection states: IDLE, ALL_RED, GREEN, YELLOW, LEFT, WALK, BLINK, VIP_G. One down-counter per intersection, TW bits.
- Lamp decode (Moore, from the state register):
  - IDLE / ALL_RED: car 1000, walk 10
  - GREEN: car 0001, walk 10
  - YELLOW: car 0100, walk 10
  - LEFT: car 1010, walk 10
  - WALK: car 1000, walk 01
  - BLINK: car 1000, walk {0,b}
  - VIP_G: car 0001, walk 10
- Blink bit b starts at 1 on BLINK entry and toggles every BLINK_DIV cycles.
- Every timed state lasts exactly its parameter in cycles. On entry the counter loads T-1. The state exits on the edge where the counter is 0.
- Normal cycle: ALL_RED → GREEN → YELLOW → LEFT (skipped if LEFT_T=0) → WALK → BLINK → ALL_RED.
- IDLE with start=1: on that edge enter ALL_RED with counter ALL_RED_T-1 + i*OFFSET_T.
- start=0 in any state: IDLE on the next edge, counter cleared, blink cleared.
- Preemption for intersection i, with grant g=vip_grant[i]:
  - GREEN with g: next edge VIP_G, counter frozen.
  - YELLOW: runs to completion; at its end go to ALL_RED if g.
  - LEFT with g: next edge ALL_RED (full ALL_RED_T).
  - WALK with g: next edge BLINK (full BLINK_T), then ALL_RED.
  - ALL_RED end: VIP_G if g, else GREEN.
  - VIP_G: held while g; on g=0, YELLOW next edge.
- Grant arbitration is registered:
  - VIP_EXCL=0: vip_grant = vip_req, delayed by one cycle.
  - VIP_EXCL=1: the holder keeps the grant while its request is high. When the grant is free, the lowest-index asserted request wins. Releasing the grant and granting a new one can happen on the same edge. Other requests wait; nothing is latched, so a dropped request is forgotten.
- start=0 forces vip_grant to 0.

## Timing
- Reset values: every state IDLE; car_traffic all 1000 per intersection; walk_traffic all 10; vip_grant 0; counters 0.
- Start latency: start is sampled at edge k. Intersection i shows GREEN beginning at edge k + ALL_RED_T + i*OFFSET_T.
- Normal cycle length is ALL_RED_T+GREEN_T+YELLOW_T+LEFT_T+WALK_T+BLINK_T; defaults give 98 cycles.
- VIP latency: vip_req rises before edge e. vip_grant rises at e. The state reacts at e+1.
- Reset asserted mid-phase: immediate IDLE, with no clearance interval.
- An invariant a checker must enforce: car G or L asserted never overlaps walk G on the same intersection.

## Test plan
- Reset/start: hold rst_n=0 → car_traffic=8'h88, walk_traffic=4'hA. Release and raise start at edge k → car[3:0]=0001 from edge k+3; car[7:4]=0001 from edge k+11.
- Full cycle with defaults: intersection 0 shows GREEN 40, YELLOW 5, LEFT 10, WALK 30, BLINK 10, ALL_RED 3 cycles. The walk G bit toggles every 2 cycles through BLINK. Period is 98 cycles.
- VIP in GREEN: vip_req=2'b01 mid-GREEN for 50 cycles → car[3:0] stays 0001. Release → 0100 for 5 cycles, then the normal cycle resumes.
- VIP in WALK: vip_req[0]=1 → walk blinks for 10 cycles, then 3 cycles all-red, then car 0001 held. Release → YELLOW.
- Exclusive arbitration: vip_req=2'b11 simultaneously → vip_grant=01. Drop bit 0 → vip_grant=10 on the following edge.
- start=0 mid-operation (including during VIP_G) → all outputs 1000/10 and vip_grant=0 one edge later.
